// File: rtl/fib_hash_arbiter.sv
// fib_hash_arbiter: shares one prefix-hash unit between the FIB insert path
// and the LPM lookup path. Round-robin on ties, one transaction at a time:
// IDLE (grant) -> ISSUE (hash_start) -> WAIT (latency) -> RESP (ack).
module fib_hash_arbiter #(
  parameter int HASH_LATENCY = 2,
  parameter int PREFIX_W     = 64,
  parameter int LEN_W        = 6,
  parameter int HASH_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_req,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  output logic                ins_ack,
  output logic [HASH_W-1:0]   ins_hash,
  input  logic                lkp_req,
  input  logic [PREFIX_W-1:0] lkp_prefix,
  input  logic [LEN_W-1:0]    lkp_len,
  output logic                lkp_ack,
  output logic [HASH_W-1:0]   lkp_hash,
  output logic [PREFIX_W-1:0] hash_prefix_in,
  output logic [LEN_W-1:0]    hash_len_in,
  output logic                hash_start,
  input  logic [HASH_W-1:0]   hash,
  output logic                busy,
  output logic                grant_lkp
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;
  logic               any_req;
  logic               pick_lkp;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req  = ins_req | lkp_req;
    pick_lkp = lkp_req & (~ins_req | ~last_grant);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; every latency (including 1) passes through WAIT so the
  // hash is always sampled at the end of cycle ISSUE+HASH_LATENCY.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the current state and the latched owner.
  always_comb begin
    hash_start = (state == ISSUE);
    busy       = (state != IDLE);
    ins_ack    = (state == RESP) && !grant_lkp;
    lkp_ack    = (state == RESP) &&  grant_lkp;
  end

  // Datapath: operand latch at grant, latency counter, per-requester results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hash_prefix_in <= '0;
      hash_len_in    <= '0;
      grant_lkp      <= 1'b0;
      last_grant     <= 1'b1;
      cnt            <= '0;
      ins_hash       <= '0;
      lkp_hash       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            hash_prefix_in <= pick_lkp ? lkp_prefix : ins_prefix;
            hash_len_in    <= pick_lkp ? lkp_len    : ins_len;
            grant_lkp      <= pick_lkp;
            last_grant     <= pick_lkp;
          end
        end
        ISSUE: begin
          cnt <= CNT_W'(HASH_LATENCY - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            if (grant_lkp) lkp_hash <= hash;
            else           ins_hash <= hash;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          hash_prefix_in <= '0;
          hash_len_in    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Directed bench for fib_hash_arbiter: one instance at HASH_LATENCY=2 and one
// at HASH_LATENCY=1, each fed by a hash model that presents the real hash only
// in the cycle it must be sampled.
module tb_fib_hash_arbiter;

  localparam int PW = 64;
  localparam int LW = 6;
  localparam int HW = 10;
  localparam logic [HW-1:0] GARBAGE = 10'h2AA;

  logic clk;
  logic rst;

  logic          ins_req, lkp_req;
  logic [PW-1:0] ins_prefix, lkp_prefix;
  logic [LW-1:0] ins_len, lkp_len;
  logic          ins_ack, lkp_ack;
  logic [HW-1:0] ins_hash, lkp_hash, hash;
  logic [PW-1:0] hash_prefix_in;
  logic [LW-1:0] hash_len_in;
  logic          hash_start, busy, grant_lkp;

  logic          ins_req_l1;
  logic [PW-1:0] ins_prefix_l1;
  logic [LW-1:0] ins_len_l1;
  logic          ins_ack_l1, lkp_ack_l1;
  logic [HW-1:0] ins_hash_l1, lkp_hash_l1, hash_l1;
  logic [PW-1:0] hash_prefix_in_l1;
  logic [LW-1:0] hash_len_in_l1;
  logic          hash_start_l1, busy_l1, grant_lkp_l1;
  logic          lkp_req_l1;
  logic [PW-1:0] lkp_prefix_l1;
  logic [LW-1:0] lkp_len_l1;

  int checks   = 0;
  int failures = 0;
  int ins_acks = 0;
  int lkp_acks = 0;
  int lkp_acks_l1 = 0;
  int cyc;

  localparam logic [PW-1:0] P1  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [PW-1:0] IP2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [PW-1:0] LP  = 64'h0000_0000_0000_0ABC;
  localparam logic [PW-1:0] IP3 = 64'h0000_0000_0005_5AA5;
  localparam logic [PW-1:0] P6  = 64'h1234_5678_9ABC_DEF0;

  fib_hash_arbiter #(.HASH_LATENCY(2), .PREFIX_W(PW), .LEN_W(LW), .HASH_W(HW)) u_dut (
    .clk(clk), .rst(rst),
    .ins_req(ins_req), .ins_prefix(ins_prefix), .ins_len(ins_len),
    .ins_ack(ins_ack), .ins_hash(ins_hash),
    .lkp_req(lkp_req), .lkp_prefix(lkp_prefix), .lkp_len(lkp_len),
    .lkp_ack(lkp_ack), .lkp_hash(lkp_hash),
    .hash_prefix_in(hash_prefix_in), .hash_len_in(hash_len_in),
    .hash_start(hash_start), .hash(hash),
    .busy(busy), .grant_lkp(grant_lkp)
  );

  fib_hash_arbiter #(.HASH_LATENCY(1), .PREFIX_W(PW), .LEN_W(LW), .HASH_W(HW)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .ins_req(ins_req_l1), .ins_prefix(ins_prefix_l1), .ins_len(ins_len_l1),
    .ins_ack(ins_ack_l1), .ins_hash(ins_hash_l1),
    .lkp_req(lkp_req_l1), .lkp_prefix(lkp_prefix_l1), .lkp_len(lkp_len_l1),
    .lkp_ack(lkp_ack_l1), .lkp_hash(lkp_hash_l1),
    .hash_prefix_in(hash_prefix_in_l1), .hash_len_in(hash_len_in_l1),
    .hash_start(hash_start_l1), .hash(hash_l1),
    .busy(busy_l1), .grant_lkp(grant_lkp_l1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference hash used by the hash-unit models and for expected results.
  function automatic logic [HW-1:0] model_hash(input logic [PW-1:0] p, input logic [LW-1:0] l);
    return p[9:0] ^ p[19:10] ^ {l, 4'b0000} ^ 10'h354;
  endfunction

  // Hash-unit model (latency 2): real value only across the sampling edge.
  logic [3:0]    m_cnt = '0;
  logic          m_armed = 1'b0;
  logic [HW-1:0] m_val = '0;
  always @(negedge clk) begin
    if (hash_start) begin
      m_cnt   <= 4'd2;
      m_armed <= 1'b1;
      m_val   <= model_hash(hash_prefix_in, hash_len_in);
    end else if (m_armed) begin
      if (m_cnt == 4'd0) m_armed <= 1'b0;
      else               m_cnt   <= m_cnt - 4'd1;
    end
  end
  assign hash = (m_armed && m_cnt == 4'd0) ? m_val : GARBAGE;

  // Hash-unit model (latency 1).
  logic [3:0]    m1_cnt = '0;
  logic          m1_armed = 1'b0;
  logic [HW-1:0] m1_val = '0;
  always @(negedge clk) begin
    if (hash_start_l1) begin
      m1_cnt   <= 4'd1;
      m1_armed <= 1'b1;
      m1_val   <= model_hash(hash_prefix_in_l1, hash_len_in_l1);
    end else if (m1_armed) begin
      if (m1_cnt == 4'd0) m1_armed <= 1'b0;
      else                m1_cnt   <= m1_cnt - 4'd1;
    end
  end
  assign hash_l1 = (m1_armed && m1_cnt == 4'd0) ? m1_val : GARBAGE;

  // Ack pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ins_ack === 1'b1) ins_acks++;
    if (lkp_ack === 1'b1) lkp_acks++;
    if (lkp_ack_l1 === 1'b1) lkp_acks_l1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ireq, input logic [PW-1:0] ipfx, input logic [LW-1:0] ilen,
                               input logic lreq, input logic [PW-1:0] lpfx, input logic [LW-1:0] llen);
    ins_req    = ireq;
    ins_prefix = ipfx;
    ins_len    = ilen;
    lkp_req    = lreq;
    lkp_prefix = lpfx;
    lkp_len    = llen;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitAck(input int budget, output int cycles);
    cycles = 0;
    while (ins_ack !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    ins_req_l1 = 1'b0; ins_prefix_l1 = '0; ins_len_l1 = '0;
    lkp_req_l1 = 1'b0; lkp_prefix_l1 = '0; lkp_len_l1 = '0;

    // Reset state
    tick(); tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_hash_start", hash_start, 0);
    checkOutput("rst_acks", {ins_ack, lkp_ack}, 0);
    checkOutput("rst_grant_lkp", grant_lkp, 0);
    checkOutput("rst_prefix", hash_prefix_in, 0);
    checkOutput("rst_len", hash_len_in, 0);
    checkOutput("rst_hashes", {ins_hash, lkp_hash}, 0);
    rst = 1'b1;
    tick();

    // Test 1: single insert
    $display("[TB] single insert");
    applyStimulus(1'b1, P1, 6'd32, 1'b0, '0, '0);
    tick();
    checkOutput("t1_hash_start", hash_start, 1);
    checkOutput("t1_prefix", hash_prefix_in, P1);
    checkOutput("t1_len", hash_len_in, 32);
    checkOutput("t1_grant_lkp", grant_lkp, 0);
    tick();
    checkOutput("t1_start_pulse", hash_start, 0);
    tick();
    checkOutput("t1_no_early_ack", ins_ack, 0);
    tick();
    checkOutput("t1_ins_ack", ins_ack, 1);
    checkOutput("t1_ins_hash", ins_hash, 10'h155);
    checkOutput("t1_lkp_ack", lkp_ack, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("t1_idle", busy, 0);
    checkOutput("t1_prefix_cleared", hash_prefix_in, 0);
    checkOutput("t1_ins_hash_hold", ins_hash, 10'h155);
    checkOutput("t1_ack_counts", {ins_acks[7:0], lkp_acks[7:0]}, {8'd1, 8'd0});

    // Test 2: simultaneous requests right after reset
    $display("[TB] tie after reset");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(1'b1, IP2, 6'd8, 1'b1, LP, 6'd32);
    tick();
    checkOutput("t2_first_grant", grant_lkp, 0);
    checkOutput("t2_first_prefix", hash_prefix_in, IP2);
    tick(); tick(); tick();
    checkOutput("t2_ins_ack", ins_ack, 1);
    checkOutput("t2_ins_hash", ins_hash, model_hash(IP2, 6'd8));
    applyStimulus(1'b0, '0, '0, 1'b1, LP, 6'd32);
    tick(); tick();
    checkOutput("t2_second_grant", grant_lkp, 1);
    checkOutput("t2_second_len", hash_len_in, 32);
    tick(); tick();
    checkOutput("t2_lkp_early", lkp_ack, 0);
    tick();
    checkOutput("t2_lkp_ack", lkp_ack, 1);
    checkOutput("t2_lkp_hash", lkp_hash, model_hash(LP, 6'd32));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();

    // Test 3/4: LPM walk with an insert arriving mid-walk, operand latching
    $display("[TB] lpm walk with interleaved insert");
    applyStimulus(1'b0, '0, '0, 1'b1, LP, 6'd32);
    tick();
    checkOutput("t3_g1_lkp", grant_lkp, 1);
    tick();
    applyStimulus(1'b1, IP3, 6'd16, 1'b1, LP, 6'd32);
    tick(); tick();
    checkOutput("t3_g1_ack", lkp_ack, 1);
    checkOutput("t3_g1_hash", lkp_hash, model_hash(LP, 6'd32));
    applyStimulus(1'b1, IP3, 6'd16, 1'b1, LP, 6'd31);
    tick();
    checkOutput("t3_idle_gap", busy, 0);
    tick();
    checkOutput("t3_g2_ins", grant_lkp, 0);
    checkOutput("t3_g2_prefix", hash_prefix_in, IP3);
    tick(); tick(); tick();
    checkOutput("t3_g2_ack", ins_ack, 1);
    checkOutput("t3_g2_hash", ins_hash, model_hash(IP3, 6'd16));
    applyStimulus(1'b0, '0, '0, 1'b1, LP, 6'd31);
    tick(); tick();
    checkOutput("t3_g3_lkp", grant_lkp, 1);
    checkOutput("t3_g3_len", hash_len_in, 31);
    tick(); tick(); tick();
    checkOutput("t3_g3_ack", lkp_ack, 1);
    checkOutput("t3_g3_hash", lkp_hash, model_hash(LP, 6'd31));
    applyStimulus(1'b0, '0, '0, 1'b1, LP, 6'd30);
    tick(); tick();
    checkOutput("t3_g4_lkp", grant_lkp, 1);
    checkOutput("t3_g4_len", hash_len_in, 30);
    applyStimulus(1'b0, '0, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5);
    tick();
    checkOutput("t4_prefix_held", hash_prefix_in, LP);
    checkOutput("t4_len_held", hash_len_in, 30);
    tick(); tick();
    checkOutput("t3_g4_ack", lkp_ack, 1);
    checkOutput("t3_g4_hash", lkp_hash, model_hash(LP, 6'd30));
    checkOutput("t3_ins_hash_kept", ins_hash, model_hash(IP3, 6'd16));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("t4_prefix_cleared", hash_prefix_in, 0);
    checkOutput("t4_len_cleared", hash_len_in, 0);
    checkOutput("t3_ack_counts", {ins_acks[7:0], lkp_acks[7:0]}, {8'd3, 8'd4});

    // Test 5: reset during WAIT aborts the transaction
    $display("[TB] reset mid-transaction");
    applyStimulus(1'b1, '0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("t5_issue", hash_start, 1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_outputs", {ins_ack, lkp_ack, hash_start, grant_lkp}, 0);
    checkOutput("t5_prefix", hash_prefix_in, 0);
    checkOutput("t5_hashes", {ins_hash, lkp_hash}, 0);
    rst = 1'b1;
    tick(); tick(); tick();
    checkOutput("t5_no_ack", ins_acks, 3);
    applyStimulus(1'b1, '0, '0, 1'b0, '0, '0);
    waitAck(10, cyc);
    checkOutput("t5_ack_seen", ins_ack, 1);
    checkOutput("t5_latency", cyc, 4);
    checkOutput("t5_zero_hash", ins_hash, 10'h354);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();

    // Test 6: HASH_LATENCY = 1 build
    $display("[TB] latency-1 build");
    ins_req_l1 = 1'b1; ins_prefix_l1 = P6; ins_len_l1 = 6'd12;
    tick();
    checkOutput("t6_hash_start", hash_start_l1, 1);
    checkOutput("t6_len", hash_len_in_l1, 12);
    tick();
    checkOutput("t6_no_early_ack", ins_ack_l1, 0);
    checkOutput("t6_busy", busy_l1, 1);
    tick();
    checkOutput("t6_ack", ins_ack_l1, 1);
    checkOutput("t6_hash", ins_hash_l1, model_hash(P6, 6'd12));
    ins_req_l1 = 1'b0; ins_prefix_l1 = '0; ins_len_l1 = '0;
    tick();
    checkOutput("t6_idle", busy_l1, 0);
    checkOutput("t6_no_lkp_ack", lkp_acks_l1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
